// File: rtl/uart_tx_param_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_tx_param_pkg;

  localparam int UART_MAX_DATA_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  // Per-frame configuration captured at load; parity type is folded into par_bit then.
  typedef struct packed {
    logic par_en;
    logic stop2;
  } uart_frame_cfg_t;

  function automatic logic uart_parity(input logic [UART_MAX_DATA_W-1:0] data,
                                       input logic typ);
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Payload handshake and frame configuration between the controller and the transmitter.
interface uart_tx_param_if #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
);
  logic [DATA_W-1:0]     P_DATA;
  logic                  DATA_VALID;
  logic                  DATA_READY;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [PRESCALE_W-1:0] PRESCALE;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
    input  DATA_READY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
    output DATA_READY
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..prescale while enabled, pulses bit_end on the last clock of a bit.
module uart_baud_tick #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_end
);
  logic [PRESCALE_W-1:0] cnt;

  // Gated so an idle counter parked at 0 never looks like a bit end when prescale is 0.
  assign bit_end = en && (cnt == prescale);

  always_ff @(posedge CLK) begin
    if (!RST)                          cnt <= '0;
    else if (!en || restart || bit_end) cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with a one-entry holding buffer, runtime prescale, optional parity, 1/2 stop bits.
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_param_if.slave bus,
  output logic           TX_OUT,
  output logic           Busy
);
  localparam int BCNT_W = $clog2(DATA_W) + 1;

  uart_tx_state_e        state, state_n;
  logic                  hold_full;
  logic [DATA_W-1:0]     hold_data;
  logic [DATA_W-1:0]     shift_reg;
  logic                  par_bit;
  uart_frame_cfg_t       cfg_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [BCNT_W-1:0]     bit_cnt;
  logic                  load, bit_end, xfer, last_data, last_stop;

  assign xfer           = bus.DATA_VALID && !hold_full;
  assign bus.DATA_READY = !hold_full;
  assign Busy           = (state != IDLE) || hold_full;
  assign last_data      = (bit_cnt == BCNT_W'(DATA_W - 1));
  assign last_stop      = (bit_cnt == BCNT_W'(cfg_q.stop2));

  uart_baud_tick #(.PRESCALE_W(PRESCALE_W)) u_tick (
    .CLK     (CLK),
    .RST     (RST),
    .en      (state != IDLE),
    .restart (load),
    .prescale(presc_q),
    .bit_end (bit_end)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    TX_OUT  = 1'b1;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        TX_OUT = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        TX_OUT = shift_reg[0];
        if (bit_end && last_data) state_n = cfg_q.par_en ? PARITY : STOP;
      end
      PARITY: begin
        TX_OUT = par_bit;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        // A queued byte reloads on the final stop edge so frames abut with no idle clock.
        if (bit_end && last_stop) begin
          if (hold_full) begin
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      cfg_q     <= '0;
      presc_q   <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_n;

      if (load)      hold_full <= 1'b0;
      else if (xfer) hold_full <= 1'b1;
      if (xfer) hold_data <= bus.P_DATA;

      if (load) begin
        shift_reg <= hold_data;
        par_bit   <= uart_parity(UART_MAX_DATA_W'(hold_data), bus.PAR_TYP);
        cfg_q     <= '{par_en: bus.PAR_EN, stop2: bus.STOP2};
        presc_q   <= bus.PRESCALE;
        bit_cnt   <= '0;
      end else if (bit_end) begin
        // bit_cnt counts data bits in DATA and stop bits in STOP; it restarts on every state change.
        bit_cnt <= (state_n != state) ? '0 : bit_cnt + 1'b1;
        if (state == DATA) shift_reg <= shift_reg >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: 8-bit and 5-bit builds against a queue-based line-level reference model.
module tb_uart_tx_param;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_param_if #(.DATA_W(8), .PRESCALE_W(6)) i8 ();
  uart_tx_param_if #(.DATA_W(5), .PRESCALE_W(6)) i5 ();
  logic tx8, busy8, tx5, busy5;

  uart_tx_param #(.DATA_W(8), .PRESCALE_W(6)) u8 (
    .CLK(CLK), .RST(RST), .bus(i8.slave), .TX_OUT(tx8), .Busy(busy8));
  uart_tx_param #(.DATA_W(5), .PRESCALE_W(6)) u5 (
    .CLK(CLK), .RST(RST), .bus(i5.slave), .TX_OUT(tx5), .Busy(busy5));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each accepted byte waits in a one-deep slot, then expands into per-clock line levels.
  bit         pend_v[2];
  logic [8:0] pend_d[2];
  bit         lq0[$];
  bit         lq1[$];
  bit         exp_tx[2];
  bit         exp_busy[2];
  int         busy_cnt8, busy_cnt5, rdy_low8;
  bit         rec8[$];
  bit         rec5[$];

  function automatic int qsize(input int id);
    return (id == 0) ? lq0.size() : lq1.size();
  endfunction

  task automatic qpush(input int id, input bit b);
    if (id == 0) lq0.push_back(b); else lq1.push_back(b);
  endtask

  task automatic qpop(input int id);
    bit b;
    if (id == 0) b = lq0.pop_front(); else b = lq1.pop_front();
  endtask

  function automatic bit qhead(input int id);
    return (id == 0) ? lq0[0] : lq1[0];
  endfunction

  task automatic push_frame(input int id, input int dw, input logic [8:0] d,
                            input logic pe, input logic pt, input logic s2, input int presc);
    bit fb[$];
    int ones = 0;
    fb.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      fb.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) fb.push_back(bit'(ones % 2) ^ pt);
    fb.push_back(1'b1);
    if (s2) fb.push_back(1'b1);
    foreach (fb[i]) for (int r = 0; r <= presc; r++) qpush(id, fb[i]);
  endtask

  task automatic model_step(input int id, input int dw, input logic vld, input logic [8:0] d,
                            input logic pe, input logic pt, input logic s2, input int presc);
    bit was_p;
    if (!RST) begin
      pend_v[id] = 1'b0;
      if (id == 0) lq0.delete(); else lq1.delete();
    end else begin
      was_p = pend_v[id];
      if (qsize(id) > 0) qpop(id);
      if (qsize(id) == 0 && was_p) begin
        push_frame(id, dw, pend_d[id], pe, pt, s2, presc);
        pend_v[id] = 1'b0;
      end
      if (vld && !was_p) begin
        pend_v[id] = 1'b1;
        pend_d[id] = d;
      end
    end
    exp_tx[id]   = (qsize(id) == 0) ? 1'b1 : qhead(id);
    exp_busy[id] = (qsize(id) != 0) || pend_v[id];
  endtask

  task automatic tick();
    model_step(0, 8, i8.DATA_VALID, {1'b0, i8.P_DATA}, i8.PAR_EN, i8.PAR_TYP, i8.STOP2,
               int'(i8.PRESCALE));
    model_step(1, 5, i5.DATA_VALID, 9'(i5.P_DATA), i5.PAR_EN, i5.PAR_TYP, i5.STOP2,
               int'(i5.PRESCALE));
    @(posedge CLK);
    @(negedge CLK);
    chk("tx8",   tx8,           exp_tx[0]);
    chk("busy8", busy8,         exp_busy[0]);
    chk("rdy8",  i8.DATA_READY, !pend_v[0]);
    chk("tx5",   tx5,           exp_tx[1]);
    chk("busy5", busy5,         exp_busy[1]);
    chk("rdy5",  i5.DATA_READY, !pend_v[1]);
    if (busy8) busy_cnt8++;
    if (busy5) busy_cnt5++;
    if (!i8.DATA_READY) rdy_low8++;
    rec8.push_back(tx8);
    rec5.push_back(tx5);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int id, input logic [8:0] d, output int stalls);
    bit acc, rdy;
    acc = 1'b0;
    stalls = 0;
    if (id == 0) begin i8.P_DATA = d[7:0]; i8.DATA_VALID = 1'b1; end
    else         begin i5.P_DATA = d[4:0]; i5.DATA_VALID = 1'b1; end
    for (int g = 0; g < 1000 && !acc; g++) begin
      rdy = !pend_v[id];
      tick();
      if (rdy) acc = 1'b1; else stalls++;
    end
    i8.DATA_VALID = 1'b0;
    i5.DATA_VALID = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 3000 && (exp_busy[0] || exp_busy[1]); g++) tick();
    chk("idle_timeout", 32'(exp_busy[0] | exp_busy[1]), 32'd0);
  endtask

  task automatic clr();
    rec8.delete();
    rec5.delete();
    busy_cnt8 = 0;
    busy_cnt5 = 0;
    rdy_low8  = 0;
  endtask

  function automatic int lows8(input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) if (rec8[i] == 1'b0) n++;
    return n;
  endfunction

  initial begin
    int st;
    logic [9:0] w10;
    logic [6:0] w7a, w7b;

    i8.P_DATA = '0; i8.DATA_VALID = 1'b0; i8.PAR_EN = 1'b0; i8.PAR_TYP = 1'b0;
    i8.STOP2 = 1'b0; i8.PRESCALE = '0;
    i5.P_DATA = '0; i5.DATA_VALID = 1'b0; i5.PAR_EN = 1'b0; i5.PAR_TYP = 1'b0;
    i5.STOP2 = 1'b0; i5.PRESCALE = '0;

    RST = 1'b0;
    idle(2);
    chk("rst_tx",   tx8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_rdy",  i8.DATA_READY, 1);
    RST = 1'b1;
    idle(2);

    // 0xA5, legacy timing, no parity, one stop
    clr();
    send(0, 9'hA5, st);
    idle(14);
    for (int i = 0; i < 10; i++) w10[9-i] = rec8[1+i];
    chk("t1_seq",     w10, 10'b0101001011);
    chk("t1_busy",    busy_cnt8, 11);
    chk("t1_rdy_low", rdy_low8, 1);

    // even then odd parity on 0x07
    i8.PAR_EN = 1'b1; i8.PAR_TYP = 1'b0;
    clr();
    send(0, 9'h07, st);
    idle(15);
    chk("t2_par_even", rec8[10], 1);
    chk("t2_len_even", busy_cnt8, 12);
    i8.PAR_TYP = 1'b1;
    clr();
    send(0, 9'h07, st);
    idle(15);
    chk("t2_par_odd", rec8[10], 0);
    chk("t2_len_odd", busy_cnt8, 12);

    // 4-clock bits, two stop bits, all-zero payload
    i8.PAR_EN = 1'b0; i8.PAR_TYP = 1'b0; i8.STOP2 = 1'b1; i8.PRESCALE = 6'd3;
    clr();
    send(0, 9'h00, st);
    idle(50);
    chk("t3_low",  lows8(1, 36), 36);
    chk("t3_stop", lows8(37, 44), 0);
    chk("t3_len",  busy_cnt8, 45);

    // three bytes queued behind each other go out back-to-back
    i8.STOP2 = 1'b0; i8.PRESCALE = '0;
    clr();
    send(0, 9'h55, st);
    send(0, 9'h11, st);
    chk("t4_stall1", st, 1);
    send(0, 9'h22, st);
    chk("t4_stall2", st, 9);
    idle(35);
    chk("t4_busy", busy_cnt8, 31);
    chk("t4_b2b",  {rec8[10], rec8[11], rec8[20], rec8[21]}, 4'b1010);

    // reset mid-DATA with a byte pending
    send(0, 9'h3C, st);
    send(0, 9'h99, st);
    idle(2);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("t5_tx",   tx8, 1);
    chk("t5_busy", busy8, 0);
    chk("t5_rdy",  i8.DATA_READY, 1);
    clr();
    idle(30);
    chk("t5_no_resume", lows8(0, 29), 0);

    // 5-bit build, prescale changed while a frame is on the line
    i5.PRESCALE = 6'd1;
    clr();
    send(1, 9'h15, st);
    idle(3);
    i5.PRESCALE = 6'd5;
    send(1, 9'h15, st);
    wait_idle();
    for (int j = 0; j < 7; j++) begin
      w7a[6-j] = rec5[1 + 2*j];
      w7b[6-j] = rec5[15 + 6*j + 3];
    end
    chk("t6_frame_a", w7a, 7'b0101011);
    chk("t6_frame_b", w7b, 7'b0101011);
    chk("t6_busy",    busy_cnt5, 57);
    chk("t6_a_edge",  {rec5[2], rec5[3]}, 2'b01);

    // random traffic with configuration changing at arbitrary times
    for (int n = 0; n < 40; n++) begin
      i8.PAR_EN   = 1'($urandom);
      i8.PAR_TYP  = 1'($urandom);
      i8.STOP2    = 1'($urandom);
      i8.PRESCALE = 6'($urandom_range(0, 3));
      send(0, 9'($urandom_range(0, 255)), st);
      idle($urandom_range(0, 12));
    end
    wait_idle();
    for (int n = 0; n < 12; n++) begin
      i5.PAR_EN   = 1'($urandom);
      i5.PAR_TYP  = 1'($urandom);
      i5.STOP2    = 1'($urandom);
      i5.PRESCALE = 6'($urandom_range(0, 2));
      send(1, 9'($urandom_range(0, 31)), st);
      idle($urandom_range(0, 8));
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the next generation of the system's serial TX path.
- Generalises the fixed 8-bit, one-clock-per-bit transmitter to configurable data width, runtime bit-time prescale, optional parity and 1 or 2 stop bits.
- Adds a one-entry holding buffer with a valid/ready handshake, so the system controller can queue the next byte while the current frame is shifting.
- Consecutive frames go out back-to-back with no idle gap.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
PRESCALE_W, 6, width of the PRESCALE port; each bit lasts PRESCALE+1 clocks.

Ports:
CLK  in  1  system clock.
RST  in  1  synchronous reset, active-low.
P_DATA  in  DATA_W  frame payload, sent LSB first.
DATA_VALID  in  1  payload offered.
DATA_READY  out  1  holding buffer empty; a transfer occurs on a rising edge with DATA_VALID && DATA_READY.
PAR_EN  in  1  1 = insert parity bit.
PAR_TYP  in  1  0 = even, 1 = odd.
STOP2  in  1  1 = two stop bits, 0 = one.
PRESCALE  in  PRESCALE_W  clocks per bit minus one.
TX_OUT  out  1  serial line, idle high.
Busy  out  1  frame in progress or byte pending.

Behaviour:
- Clock and reset: one clock (CLK); RST synchronous, active-low. Any edge with RST=0 forces IDLE, empties the holding buffer and clears all counters, including mid-frame. From the next cycle: TX_OUT=1, Busy=0, DATA_READY=1. A truncated frame is not resumed.
- Holding buffer: DATA_READY = !hold_full, registered.
  - Transfer at edge k stores P_DATA; hold_full=1 from cycle k+1.
  - No transfer while full; DATA_VALID with READY=0 is ignored.
- Load: config (PAR_EN, PAR_TYP, STOP2, PRESCALE) is sampled when the FSM loads from the holding buffer. It is held constant for the whole frame; changes mid-frame take effect at the next load.
- Load edge: hold_full is cleared, the shift register is loaded, and the parity bit is computed as ^data ^ PAR_TYP.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1. At the edge where hold_full=1, load and go to START. A byte accepted at edge k starts its start bit at cycle k+2.
  - START: TX_OUT=0 for PRESCALE+1 clocks, then DATA.
  - DATA: TX_OUT=shift_reg[0]. At each bit end, shift right and increment the bit counter. After DATA_W bits, go to PARITY if PAR_EN, else STOP.
  - PARITY: TX_OUT=parity bit for one bit time, then STOP.
  - STOP: TX_OUT=1 for 1 or 2 bit times (STOP2). At the final bit end, if hold_full, load and go directly to START (back-to-back); otherwise go to IDLE.
- Bit timing:
  - Tick counter reloads to 0 at each load and at each bit end.
  - A bit end occurs when the counter equals the latched PRESCALE.
  - PRESCALE=0 gives one clock per bit (legacy timing).
  - Frame length in clocks = (PRESCALE+1) * (1 + DATA_W + PAR_EN + 1 + STOP2).
- Busy = (state != IDLE) || hold_full, combinational from registers.
- TX_OUT is decoded from registered state and shift_reg only (no input paths), so it is glitch-free.
- Widths: bit counter is $clog2(DATA_W)+1 bits; tick counter is PRESCALE_W bits, with no wrap inside a bit.

Decomposition:
- SYS_PKG gets:
  - uart_tx_state_e (IDLE, START, DATA, PARITY, STOP).
  - Function uart_parity(data, typ).
  - Constant UART_MAX_DATA_W = 9.
- One sub-module: uart_baud_tick. It is a PRESCALE_W counter with a restart input, the latched prescale, and a single-cycle bit_end output.

Test Plan:
1. Reset, then DATA_W=8, PRESCALE=0, PAR_EN=0, STOP2=0, send 0xA5 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 over 10 clocks; Busy high for exactly 11 cycles; DATA_READY low for 1 cycle.
2. PAR_EN=1, PAR_TYP=0, 0x07, then PAR_TYP=1, 0x07 -> parity bit 1 then 0; each frame 11 bit times.
3. PRESCALE=3, STOP2=1, 0x00 -> each bit held 4 clocks; start+8 zeros = 36 low clocks, then 8 high clocks; total frame 44 clocks.
4. Present 0x11 and 0x22 on consecutive handshakes during frame 1 -> second DATA_VALID stalled until load; frame 2 start bit immediately follows frame 1 stop bit, with no idle cycle.
5. Assert RST=0 for one cycle in the middle of DATA with a byte pending -> next cycle TX_OUT=1, Busy=0, DATA_READY=1; the pending byte is never transmitted.
6. DATA_W=5 build, PRESCALE change mid-frame from 1 to 5 -> current frame keeps 2-clock bits; next frame uses 6-clock bits; 0x15 sent as 1,0,1,0,1.
